// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with optional parity and line-break handling.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // Tick counter must reach both 15 (bit period) and SB_TICK-1 (stop period).
  localparam int unsigned S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic            rx_meta;
  logic            rx_s;
  logic [2:0]      state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            done_c;
  logic            par_calc_c;
  logic            par_err_c;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic: IDLE/BREAK watch the line every clk, others advance on s_tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_W'(7)) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_W'(DBIT - 1)) begin
              state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            s_d     = '0;
            done_c  = 1'b1;
            state_d = rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Parity check: even wants data^parity == 0, odd wants 1.
  assign par_calc_c = (^b_q) ^ par_q;
  assign par_err_c  = (PARITY == 1) ? par_calc_c :
                      (PARITY == 2) ? ~par_calc_c : 1'b0;

  // Completion outputs, held until the next completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      rx_done_tick <= done_c;
      if (done_c) begin
        dout       <= b_q;
        frame_err  <= ~rx_s;
        parity_err <= par_err_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into three receiver configurations and scores results.
module tb_uart_rx;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  logic       done0, done1, done2;
  logic       fe0, fe1, fe2;
  logic       pe0, pe1, pe2;

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   cnt[3];
  int   n_cmp = 0;
  int   n_bad = 0;

  // 8N1, no parity
  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .s_tick(s_tick),
    .dout(dout0), .rx_done_tick(done0), .frame_err(fe0), .parity_err(pe0));

  // 8E1
  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .s_tick(s_tick),
    .dout(dout1), .rx_done_tick(done1), .frame_err(fe1), .parity_err(pe1));

  // 7O2
  uart_rx #(.DBIT(7), .SB_TICK(32), .PARITY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .s_tick(s_tick),
    .dout(dout2), .rx_done_tick(done2), .frame_err(fe2), .parity_err(pe2));

  always #5 clk = ~clk;

  // 16x tick: one clk high every 8 clks
  initial begin
    forever begin
      repeat (7) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a frame yields its data, stop-bit status and parity verdict.
  function automatic exp_t model(input int k, input logic [8:0] data, input logic stop_v,
                                 input logic par_v);
    exp_t e;
    logic x;
    e.d  = (k == 2) ? (data & 9'h07F) : (data & 9'h0FF);
    e.fe = ~stop_v;
    x    = (^e.d) ^ par_v;
    case (k)
      1:       e.pe = x;
      2:       e.pe = ~x;
      default: e.pe = 1'b0;
    endcase
    return e;
  endfunction

  task automatic score(input int k, input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    check($sformatf("frame_expected%0d", k), 32'(sz != 0), 32'd1);
    if (sz == 0) return;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    check($sformatf("dout%0d", k), 32'(d), 32'(e.d));
    check($sformatf("frame_err%0d", k), 32'(fe), 32'(e.fe));
    check($sformatf("parity_err%0d", k), 32'(pe), 32'(e.pe));
  endtask

  // Completion monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done0) begin cnt[0]++; score(0, 9'(dout0), fe0, pe0); end
    if (done1) begin cnt[1]++; score(1, 9'(dout1), fe1, pe1); end
    if (done2) begin cnt[2]++; score(2, 9'(dout2), fe2, pe2); end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  task automatic drive(input int k, input logic v);
    @(negedge clk);
    case (k)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Sends one frame; the line is left at the stop-bit level.
  task automatic send_frame(input int k, input logic [8:0] data, input logic stop_v,
                            input logic par_v);
    exp_t e;
    int   nb;
    int   sb;
    nb = (k == 2) ? 7 : 8;
    sb = (k == 2) ? 32 : 16;
    e  = model(k, data, stop_v, par_v);
    drive(k, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      drive(k, data[i]);
      wait_ticks(16);
    end
    if (k != 0) begin
      drive(k, par_v);
      wait_ticks(16);
    end
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    drive(k, stop_v);
    wait_ticks(sb);
  endtask

  task automatic rand_run(input int k);
    logic [8:0] d;
    logic       st;
    logic       p;
    wait_ticks($urandom_range(0, 5));
    for (int i = 0; i < 6; i++) begin
      d  = 9'($urandom);
      st = ($urandom_range(0, 4) != 0);
      p  = 1'($urandom_range(0, 1));
      send_frame(k, d, st, p);
      if (!st) begin
        wait_ticks($urandom_range(0, 10));
        drive(k, 1'b1);
        wait_ticks(1);
      end
      wait_ticks($urandom_range(0, 6));
    end
  endtask

  int c;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_dout0", 32'(dout0), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_fe0", 32'(fe0), 32'd0);
    check("rst_pe1", 32'(pe1), 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // basic frame
    c = cnt[0];
    send_frame(0, 9'h0A5, 1'b1, 1'b0);
    check("a5_count", 32'(cnt[0]), 32'(c + 1));

    // false start: short low pulse
    c = cnt[0];
    drive(0, 1'b0);
    wait_ticks(4);
    drive(0, 1'b1);
    wait_ticks(20);
    check("false_start_count", 32'(cnt[0]), 32'(c));
    check("false_start_dout", 32'(dout0), 32'h0A5);
    send_frame(0, 9'h03C, 1'b1, 1'b0);
    check("3c_count", 32'(cnt[0]), 32'(c + 1));

    // framing error followed by a held break
    c = cnt[0];
    send_frame(0, 9'h081, 1'b0, 1'b0);
    wait_ticks(40);
    check("break_count", 32'(cnt[0]), 32'(c + 1));
    check("break_fe", 32'(fe0), 32'd1);
    drive(0, 1'b1);
    wait_ticks(4);
    send_frame(0, 9'h055, 1'b1, 1'b0);
    check("55_count", 32'(cnt[0]), 32'(c + 2));
    check("55_fe", 32'(fe0), 32'd0);

    // parity: even and odd receivers
    send_frame(1, 9'h007, 1'b1, 1'b0);
    check("even_bad_pe", 32'(pe1), 32'd1);
    send_frame(1, 9'h007, 1'b1, 1'b1);
    check("even_good_pe", 32'(pe1), 32'd0);
    check("even_dout", 32'(dout1), 32'h07);
    send_frame(2, 9'h007, 1'b1, 1'b0);
    check("odd_good_pe", 32'(pe2), 32'd0);
    send_frame(2, 9'h007, 1'b1, 1'b1);
    check("odd_bad_pe", 32'(pe2), 32'd1);

    // reset in the middle of data bit 4
    c = cnt[0];
    drive(0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0);
      wait_ticks(16);
    end
    drive(0, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_dout0", 32'(dout0), 32'd0);
    check("mid_rst_dout1", 32'(dout1), 32'd0);
    check("mid_rst_pe2", 32'(pe2), 32'd0);
    rst_n = 1'b1;
    wait_ticks(24);
    check("mid_rst_count", 32'(cnt[0]), 32'(c));
    send_frame(0, 9'h0F0, 1'b1, 1'b0);
    check("f0_count", 32'(cnt[0]), 32'(c + 1));

    // back-to-back frames
    c = cnt[0];
    send_frame(0, 9'h012, 1'b1, 1'b0);
    send_frame(0, 9'h034, 1'b1, 1'b0);
    check("b2b_count", 32'(cnt[0]), 32'(c + 2));
    check("b2b_dout", 32'(dout0), 32'h34);

    // randomized traffic on all three receivers at once
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    wait_ticks(4);

    check("pending0", 32'(q0.size()), 32'd0);
    check("pending1", 32'(q1.size()), 32'd0);
    check("pending2", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
